gate_truth_table_checker: RTL and testbench
===========================================

Name: gate_truth_table_checker

Overview:
- Synthesisable, parametrised successor of the lab's toggle-based gate stimulus.
- Drives all 2^N input combinations of an N-input combinational gate DUT in binary order, holding each vector for HOLD clocks.
- Compares the DUT output against the gate function selected by mode, and reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the gate under test in lab top-levels and board demos (vector to DUT inputs, dut_out back).

Parameters:
- N, 3, number of gate inputs; legal range 1..16.
- HOLD, 2, clocks each vector is held before the output is sampled; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  synchronous; terminates a running sweep.
- mode  in  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND.
- dut_out  in  1  output of the gate under test.
- vec  out  N  stimulus to the DUT inputs; vec[0] toggles fastest.
- expected  out  1  reference value for the current vec under the latched mode.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; holds until the next start.
- pass  out  1  valid when done=1; 1 when err_count==0.
- err_count  out  N+1  number of mismatching vectors. Cannot overflow: at most 2^N.
- first_err_vec  out  N  vec value at the first mismatch; 0 if there was none.
- err_seen  out  1  set at the first mismatch of a sweep.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. vec, err_count, first_err_vec and the hold counter all 0. busy, done, pass and err_seen 0. mode_q=00.
- States: IDLE, RUN, DONE.

IDLE/DONE with start=1 at edge T:
- At T+1: state=RUN, busy=1, done=0, pass=0, vec=0, hold_cnt=0, err_count=0, err_seen=0, first_err_vec=0, mode_q=mode.
- mode is latched here. Changes to mode during RUN are ignored.

Expected function:
- expected is combinational from vec and mode_q: &vec, |vec, ^vec or ~&vec.

RUN, per edge:
- If abort=1: go to IDLE. busy=0, done=0. Counters and error fields keep their values. abort has priority over everything else.
- Else if hold_cnt < HOLD-1: hold_cnt++.
- Else (sample edge): compare dut_out with expected.
  - On mismatch: err_count++. If err_seen=0, set first_err_vec=vec and err_seen=1.
  - If vec == all-ones: go to DONE. busy=0, done=1. pass = (err_count==0 after this compare's update). vec holds all-ones.
  - Otherwise: vec++ and hold_cnt=0.
- Each vector is presented for exactly HOLD cycles. dut_out is sampled on the HOLD-th edge after vec changes.
- Sweep latency: busy is high for exactly 2^N * HOLD cycles. done rises on the edge following the last sample.

Other rules:
- start while busy=1 is ignored; there is no restart mid-sweep.
- start and abort both high in IDLE/DONE: start wins, because abort only acts in RUN.
- DONE is sticky. Results stay stable until the next start or reset.
- rst_n asserted mid-sweep clears everything immediately, without waiting for a clock edge.
- No wrap-around of vec occurs, because the all-ones vector terminates the sweep.

Test Plan:
- N=3, HOLD=2, mode=AND, dut_out=&vec (ideal model), pulse start -> busy high for exactly 16 cycles; vec steps 000..111; done=1, pass=1, err_count=0, first_err_vec=000.
- Same setup, dut_out tied 0 (stuck-at-0) -> done=1, pass=0, err_count=1, first_err_vec=111, err_seen=1.
- N=3, HOLD=2, mode=XOR, DUT is an AND model -> mismatches at 001, 010 and 100 -> err_count=3, first_err_vec=001, pass=0.
- N=4, HOLD=1, mode=NAND, dut_out=~&vec -> busy for 16 cycles, pass=1. Toggling mode mid-sweep has no effect on the result.
- N=3, HOLD=2: assert abort at cycle 5 of RUN -> next edge state=IDLE, busy=0, done=0. Assert start during RUN at cycle 3 (before the abort) -> no restart; vec continues counting.
- N=3, HOLD=2: drop rst_n asynchronously mid-sweep with vec=011 -> vec=000, busy=0, err_count=0 immediately, before the next clock edge. After release, a start gives a complete correct sweep.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Exhaustive truth-table sweeper for an N-input combinational gate: drives every
// input vector in binary order, compares dut_out against the selected reference function.
module gate_truth_table_checker #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mode,
  input  logic         dut_out,
  output logic [N-1:0] vec,
  output logic         expected,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec,
  output logic         err_seen
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned EW = N + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_NAND} mode_t;

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   vec_d, first_err_vec_d;
  logic [N:0]     err_count_d, err_next;
  logic           busy_d, done_d, pass_d, err_seen_d;
  logic           mismatch;

  // Reference function of the current vector under the latched mode.
  always_comb begin
    expected = 1'b0;
    case (mode_q)
      MODE_AND:  expected = &vec;
      MODE_OR:   expected = |vec;
      MODE_XOR:  expected = ^vec;
      MODE_NAND: expected = ~&vec;
      default:   expected = 1'b0;
    endcase
  end

  assign mismatch = dut_out ^ expected;
  assign err_next = err_count + EW'(mismatch);

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    hold_d          = hold_q;
    vec_d           = vec;
    err_count_d     = err_count;
    first_err_vec_d = first_err_vec;
    err_seen_d      = err_seen;
    busy_d          = busy;
    done_d          = done;
    pass_d          = pass;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = RUN;
          mode_d          = mode_t'(mode);
          hold_d          = '0;
          vec_d           = '0;
          err_count_d     = '0;
          first_err_vec_d = '0;
          err_seen_d      = 1'b0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // Sample edge: the vector has been stable for HOLD cycles.
          if (mismatch) begin
            err_count_d = err_next;
            if (!err_seen) begin
              first_err_vec_d = vec;
              err_seen_d      = 1'b1;
            end
          end
          if (&vec) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            vec_d  = vec + N'(1);
            hold_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= MODE_AND;
      hold_q        <= '0;
      vec           <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      err_seen      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      hold_q        <= hold_d;
      vec           <= vec_d;
      err_count     <= err_count_d;
      first_err_vec <= first_err_vec_d;
      err_seen      <= err_seen_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: N=3/HOLD=2 and N=4/HOLD=1 checkers driving behavioural gate models.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=3, HOLD=2 instance; DUT model is an AND gate, optionally stuck-at-0.
  logic       start3 = 1'b0, abort3 = 1'b0, stuck3 = 1'b0;
  logic [1:0] mode3 = 2'b00;
  logic       dut_out3, expected3, busy3, done3, pass3, err_seen3;
  logic [2:0] vec3, first3;
  logic [3:0] err3;
  assign dut_out3 = stuck3 ? 1'b0 : &vec3;

  gate_truth_table_checker #(.N(3), .HOLD(2)) u_chk3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .mode(mode3),
    .dut_out(dut_out3), .vec(vec3), .expected(expected3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .first_err_vec(first3),
    .err_seen(err_seen3)
  );

  // N=4, HOLD=1 instance; DUT model is a NAND gate.
  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [1:0] mode4 = 2'b00;
  logic       dut_out4, expected4, busy4, done4, pass4, err_seen4;
  logic [3:0] vec4, first4;
  logic [4:0] err4;
  assign dut_out4 = ~&vec4;

  gate_truth_table_checker #(.N(4), .HOLD(1)) u_chk4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .mode(mode4),
    .dut_out(dut_out4), .vec(vec4), .expected(expected4), .busy(busy4),
    .done(done4), .pass(pass4), .err_count(err4), .first_err_vec(first4),
    .err_seen(err_seen4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on the N=3 checker and count busy cycles (bounded).
  task automatic sweep3(input logic [1:0] m, input bit chk_vec, output int cycles);
    @(negedge clk);
    mode3  = m;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cycles = 0;
    while (busy3 && cycles < 200) begin
      if (chk_vec) check("vec_step", 32'(vec3), 32'(cycles / 2));
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_vec",   32'(vec3), 32'd0);
    check("rst_busy",  32'(busy3), 32'd0);
    check("rst_done",  32'(done3), 32'd0);
    check("rst_pass",  32'(pass3), 32'd0);
    check("rst_err",   32'(err3), 32'd0);
    check("rst_first", 32'(first3), 32'd0);
    check("rst_seen",  32'(err_seen3), 32'd0);
    rst_n = 1'b1;

    // Ideal AND gate, AND mode.
    sweep3(2'b00, 1'b1, cyc);
    check("and_busy_cycles", 32'(cyc), 32'd16);
    check("and_done",  32'(done3), 32'd1);
    check("and_pass",  32'(pass3), 32'd1);
    check("and_err",   32'(err3), 32'd0);
    check("and_first", 32'(first3), 32'd0);
    check("and_vec_end", 32'(vec3), 32'd7);
    repeat (3) @(negedge clk);
    check("and_done_sticky", 32'(done3), 32'd1);
    check("and_expected_111", 32'(expected3), 32'd1);

    // Stuck-at-0 gate: only 111 mismatches.
    stuck3 = 1'b1;
    sweep3(2'b00, 1'b0, cyc);
    stuck3 = 1'b0;
    check("sa0_busy_cycles", 32'(cyc), 32'd16);
    check("sa0_done",  32'(done3), 32'd1);
    check("sa0_pass",  32'(pass3), 32'd0);
    check("sa0_err",   32'(err3), 32'd1);
    check("sa0_first", 32'(first3), 32'd7);
    check("sa0_seen",  32'(err_seen3), 32'd1);

    // XOR reference against an AND gate: 001, 010, 100 mismatch.
    sweep3(2'b10, 1'b0, cyc);
    check("xor_err",   32'(err3), 32'd3);
    check("xor_first", 32'(first3), 32'd1);
    check("xor_pass",  32'(pass3), 32'd0);
    check("xor_done",  32'(done3), 32'd1);

    // N=4 HOLD=1 NAND sweep with mode toggled mid-run.
    @(negedge clk);
    mode4  = 2'b11;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (busy4 && cyc < 200) begin
      if (cyc == 5) mode4 = 2'b00;
      cyc++;
      @(negedge clk);
    end
    check("nand_busy_cycles", 32'(cyc), 32'd16);
    check("nand_pass", 32'(pass4), 32'd1);
    check("nand_err",  32'(err4), 32'd0);
    check("nand_vec_end", 32'(vec4), 32'd15);

    // Start mid-sweep is ignored; abort returns to IDLE holding state.
    @(negedge clk);
    mode3  = 2'b00;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) start3 = 1'b1;
      if (c == 4) begin
        start3 = 1'b0;
        check("no_restart_vec",  32'(vec3), 32'd2);
        check("no_restart_busy", 32'(busy3), 32'd1);
      end
      if (c == 5) abort3 = 1'b1;
      if (c == 6) begin
        abort3 = 1'b0;
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_done", 32'(done3), 32'd0);
        check("abort_vec_hold", 32'(vec3), 32'd2);
      end
      if (c < 6) @(negedge clk);
    end

    // Start and abort together in IDLE: start wins.
    start3 = 1'b1;
    abort3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    abort3 = 1'b0;
    check("start_beats_abort_busy", 32'(busy3), 32'd1);
    check("start_beats_abort_vec",  32'(vec3), 32'd0);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;

    // Asynchronous reset mid-sweep with errors already counted.
    @(negedge clk);
    mode3  = 2'b10;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (vec3 != 3'd3 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("pre_rst_vec", 32'(vec3), 32'd3);
    check("pre_rst_err", 32'(err3), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vec",  32'(vec3), 32'd0);
    check("async_rst_busy", 32'(busy3), 32'd0);
    check("async_rst_err",  32'(err3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep3(2'b00, 1'b0, cyc);
    check("post_rst_busy_cycles", 32'(cyc), 32'd16);
    check("post_rst_pass", 32'(pass3), 32'd1);
    check("post_rst_err",  32'(err3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
